// File: rtl/mem_arbiter.sv
// 16x8 register file shared by an SPI register port and a core request/ack port.
// Optional MEM_ARB_LOCK_EN adds core_lock, which write-protects addresses 8..15 from SPI writes.
module mem_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] spi_addr,
  input  logic [7:0] spi_din,
  input  logic       spi_wrt,
  output logic [7:0] spi_dout,
  output logic       spi_ovf,
  input  logic       core_req,
  input  logic       core_we,
  input  logic [3:0] core_addr,
  input  logic [7:0] core_wdata,
  output logic [7:0] core_rdata,
  output logic       core_ack,
`ifdef MEM_ARB_LOCK_EN
  input  logic       core_lock,
`endif
  output logic [1:0] dbg_state_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SPIW = 2'd1;
  localparam logic [1:0] CORE = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [7:0] mem_q [16];
  logic [1:0] state_q, state_d;
  logic       pend_q, pend_d;
  logic [3:0] pend_addr_q, pend_addr_d;
  logic [7:0] pend_data_q, pend_data_d;
  logic       last_spi_q, last_spi_d;
  logic       spi_wrt_q;
  logic       ovf_q, ovf_d;
  logic [7:0] dout_q;
  logic [7:0] rdata_q, rdata_d;
  logic       ack_q;
  logic       spi_edge;
  logic       spi_blocked;
  logic       mem_we;
  logic [3:0] mem_waddr;
  logic [7:0] mem_wdata;

  assign spi_edge = spi_wrt & ~spi_wrt_q;

`ifdef MEM_ARB_LOCK_EN
  assign spi_blocked = core_lock & pend_addr_q[3];
`else
  assign spi_blocked = 1'b0;
`endif

  // Pending slot: a new edge always wins; it only counts as an overrun if the
  // previous write is not being retired in this very cycle.
  always_comb begin
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;
    ovf_d       = ovf_q;
    if (spi_edge) begin
      pend_d      = 1'b1;
      pend_addr_d = spi_addr;
      pend_data_d = spi_din;
      if (pend_q && (state_q != SPIW)) ovf_d = 1'b1;
    end else if (state_q == SPIW) begin
      pend_d = 1'b0;
    end
  end

  // An edge seen in IDLE counts as pending so a simultaneous core request
  // yields to the SPI write unless SPI was served last.
  always_comb begin
    state_d    = state_q;
    last_spi_d = last_spi_q;
    rdata_d    = rdata_q;
    mem_we     = 1'b0;
    mem_waddr  = core_addr;
    mem_wdata  = core_wdata;
    case (state_q)
      IDLE: begin
        if ((pend_q || spi_edge) && (!core_req || !last_spi_q)) state_d = SPIW;
        else if (core_req)                                      state_d = CORE;
      end
      SPIW: begin
        mem_we     = ~spi_blocked;
        mem_waddr  = pend_addr_q;
        mem_wdata  = pend_data_q;
        last_spi_d = 1'b1;
        state_d    = IDLE;
      end
      CORE: begin
        if (core_we) mem_we  = 1'b1;
        else         rdata_d = mem_q[core_addr];
        last_spi_d = 1'b0;
        state_d    = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem_q[i] <= 8'h00;
      state_q     <= IDLE;
      pend_q      <= 1'b0;
      pend_addr_q <= 4'h0;
      pend_data_q <= 8'h00;
      last_spi_q  <= 1'b0;
      spi_wrt_q   <= 1'b0;
      ovf_q       <= 1'b0;
      dout_q      <= 8'h00;
      rdata_q     <= 8'h00;
      ack_q       <= 1'b0;
    end else begin
      if (mem_we) mem_q[mem_waddr] <= mem_wdata;
      state_q     <= state_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
      last_spi_q  <= last_spi_d;
      spi_wrt_q   <= spi_wrt;
      ovf_q       <= ovf_d;
      dout_q      <= mem_q[spi_addr];
      rdata_q     <= rdata_d;
      ack_q       <= (state_q == DONE);
    end
  end

  assign spi_dout    = dout_q;
  assign spi_ovf     = ovf_q;
  assign core_rdata  = rdata_q;
  assign core_ack    = ack_q;
  assign dbg_state_o = state_q;

endmodule
